// File: rtl/pwm_ramp_controller.sv
// Rate-limited duty sequencer for the PWM generator.
// Duty updates land only on PWM period boundaries.
module pwm_ramp_controller #(
  parameter int STEP_PERIODS = 4,
  parameter int STEP_SIZE    = 1,
  parameter int MAX_DUTY     = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_duty,
  input  logic       cmd_immediate,
  output logic [7:0] duty_cycle,
  output logic       period_tick,
  output logic       busy,
  output logic       at_target
);

  typedef enum logic [1:0] {
    HOLD,
    RAMP,
    JUMP,
    OFF
  } state_t;

  localparam logic [7:0] MAX_D   = 8'(MAX_DUTY);
  localparam logic [7:0] SS8     = 8'(STEP_SIZE);
  localparam logic [7:0] SP_LAST = 8'(STEP_PERIODS - 1);

  state_t     state;
  logic [7:0] phase;
  logic [7:0] target;
  logic [7:0] interval;
  logic [7:0] cmd_clamped;
  logic [7:0] step_duty;
  logic [8:0] up_sum;
  logic       accept;

  assign period_tick = (phase == 8'hff);
  assign cmd_ready   = (state != JUMP);
  assign busy        = (state == RAMP) | (state == JUMP);
  assign at_target   = (state == HOLD);
  assign accept      = cmd_valid & cmd_ready;
  assign cmd_clamped = (cmd_duty > MAX_D) ? MAX_D : cmd_duty;
  assign up_sum      = {1'b0, duty_cycle} + {1'b0, SS8};

  // Saturate at target in both directions; down path never borrows.
  always_comb begin
    step_duty = target;
    if (target > duty_cycle) begin
      if (up_sum < {1'b0, target})
        step_duty = up_sum[7:0];
    end else if (duty_cycle >= SS8 &&
                 (duty_cycle - SS8) > target) begin
      step_duty = duty_cycle - SS8;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      phase <= 8'd0;
    else
      phase <= phase + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HOLD;
      duty_cycle <= 8'd0;
      target     <= 8'd0;
      interval   <= 8'd0;
    end else if (!enable) begin
      state    <= OFF;
      interval <= 8'd0;
      if (accept)
        target <= cmd_clamped;
      if (period_tick)
        duty_cycle <= 8'd0;
    end else if (accept && cmd_immediate) begin
      state  <= JUMP;
      target <= cmd_clamped;
    end else if (accept) begin
      target   <= cmd_clamped;
      interval <= 8'd0;
      state    <= (cmd_clamped != duty_cycle) ? RAMP : HOLD;
    end else begin
      unique case (state)
        HOLD: ;
        OFF: begin
          interval <= 8'd0;
          state    <= (target != duty_cycle) ? RAMP : HOLD;
        end
        JUMP: begin
          if (period_tick) begin
            duty_cycle <= target;
            state      <= HOLD;
          end
        end
        RAMP: begin
          if (period_tick) begin
            if (interval == SP_LAST) begin
              interval   <= 8'd0;
              duty_cycle <= step_duty;
              if (step_duty == target)
                state <= HOLD;
            end else begin
              interval <= interval + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Bench for pwm_ramp_controller: two parameterisations
// checked every cycle against an arithmetic reference model.
module tb_pwm_ramp_controller;

  logic       clk;
  logic       rst_n;
  logic [1:0] en;
  logic [1:0] v;
  logic [1:0] imm;
  logic [7:0] d [2];
  logic [7:0] duty [2];
  logic [1:0] rdy;
  logic [1:0] tk;
  logic [1:0] bsy;
  logic [1:0] at;

  int tests;
  int failed;

  int p_sp  [2] = '{4, 1};
  int p_ss  [2] = '{1, 100};
  int p_max [2] = '{255, 250};

  int m_duty [2];
  int m_tgt  [2];
  int m_wait [2];
  bit m_off  [2];
  bit m_jump [2];
  int m_phase;

  typedef struct {
    int duty;
    bit busy;
    bit at_t;
  } step_t;

  typedef struct {
    int cmd;
    int e [3];
  } clamp_t;

  step_t  ramp_tab [12];
  clamp_t clamp_tab [2];

  pwm_ramp_controller dut (
    .clk(clk), .rst_n(rst_n), .enable(en[0]),
    .cmd_valid(v[0]), .cmd_ready(rdy[0]),
    .cmd_duty(d[0]), .cmd_immediate(imm[0]),
    .duty_cycle(duty[0]), .period_tick(tk[0]),
    .busy(bsy[0]), .at_target(at[0])
  );

  pwm_ramp_controller #(
    .STEP_PERIODS(1), .STEP_SIZE(100), .MAX_DUTY(250)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]),
    .cmd_valid(v[1]), .cmd_ready(rdy[1]),
    .cmd_duty(d[1]), .cmd_immediate(imm[1]),
    .duty_cycle(duty[1]), .period_tick(tk[1]),
    .busy(bsy[1]), .at_target(at[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", n, a, e);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_duty[k] = 0;
      m_tgt[k]  = 0;
      m_wait[k] = 0;
      m_off[k]  = 0;
      m_jump[k] = 0;
    end
    m_phase = 0;
  endtask

  // Rules applied once per clock edge, from values seen before it.
  task automatic m_edge(input int k, input bit tick);
    bit acc;
    int t;
    acc = v[k] && !m_jump[k];
    t = (int'(d[k]) > p_max[k]) ? p_max[k] : int'(d[k]);
    if (!en[k]) begin
      if (acc) m_tgt[k] = t;
      m_off[k]  = 1;
      m_jump[k] = 0;
      m_wait[k] = 0;
      if (tick) m_duty[k] = 0;
    end else if (acc && imm[k]) begin
      m_tgt[k]  = t;
      m_jump[k] = 1;
      m_off[k]  = 0;
    end else if (acc) begin
      m_tgt[k]  = t;
      m_wait[k] = 0;
      m_off[k]  = 0;
    end else if (m_off[k]) begin
      m_off[k]  = 0;
      m_wait[k] = 0;
    end else if (m_jump[k]) begin
      if (tick) begin
        m_duty[k] = m_tgt[k];
        m_jump[k] = 0;
      end
    end else if (m_duty[k] != m_tgt[k] && tick) begin
      if (m_wait[k] == p_sp[k] - 1) begin
        m_wait[k] = 0;
        if (m_duty[k] < m_tgt[k])
          m_duty[k] = (m_duty[k] + p_ss[k] < m_tgt[k]) ?
                      m_duty[k] + p_ss[k] : m_tgt[k];
        else
          m_duty[k] = (m_duty[k] - p_ss[k] > m_tgt[k]) ?
                      m_duty[k] - p_ss[k] : m_tgt[k];
      end else begin
        m_wait[k]++;
      end
    end
  endtask

  task automatic check_all();
    bit idle;
    for (int k = 0; k < 2; k++) begin
      idle = !m_off[k] && !m_jump[k] && m_duty[k] == m_tgt[k];
      chk($sformatf("duty%0d", k), duty[k], m_duty[k]);
      chk($sformatf("tick%0d", k), tk[k], int'(m_phase == 255));
      chk($sformatf("ready%0d", k), rdy[k], int'(!m_jump[k]));
      chk($sformatf("busy%0d", k), bsy[k],
          int'(!m_off[k] && (m_jump[k] || m_duty[k] != m_tgt[k])));
      chk($sformatf("at_target%0d", k), at[k], int'(idle));
    end
  endtask

  task automatic cyc();
    bit tick;
    @(posedge clk);
    tick = (m_phase == 255);
    m_edge(0, tick);
    m_edge(1, tick);
    m_phase = (m_phase + 1) % 256;
    #1;
    check_all();
  endtask

  task automatic next_boundary();
    do cyc(); while (m_phase != 0);
  endtask

  task automatic to_phase(input int p);
    while (m_phase != p) cyc();
  endtask

  task automatic send(input int k, input int dv, input bit im);
    chk($sformatf("ready_at_send%0d", k), rdy[k], 1);
    v[k]   = 1'b1;
    d[k]   = 8'(dv);
    imm[k] = im;
    cyc();
    v[k]   = 1'b0;
    imm[k] = 1'b0;
  endtask

  initial begin
    int first_tick;
    int second_tick;
    int n;

    tests  = 0;
    failed = 0;
    for (int i = 0; i < 12; i++)
      ramp_tab[i] = '{(i + 1) / 4, (i + 1) < 12, (i + 1) >= 12};
    clamp_tab[0] = '{255, '{100, 200, 250}};
    clamp_tab[1] = '{5, '{150, 50, 5}};

    en = 2'b11; v = 2'b00; imm = 2'b00;
    d[0] = 8'd0; d[1] = 8'd0;
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty", duty[0], 0);
    chk("rst_ready", rdy[0], 1);
    chk("rst_busy", bsy[0], 0);
    chk("rst_at_target", at[0], 1);
    chk("rst_tick", tk[0], 0);
    rst_n = 1'b1;

    first_tick = -1;
    second_tick = -1;
    for (int c = 1; c <= 600; c++) begin
      cyc();
      if (tk[0] && first_tick < 0) first_tick = c;
      else if (tk[0] && second_tick < 0) second_tick = c;
    end
    chk("first_tick", first_tick, 255);
    chk("second_tick", second_tick, 511);
    chk("idle_duty", duty[0], 0);

    send(0, 3, 1'b0);
    for (int i = 0; i < 12; i++) begin
      next_boundary();
      chk($sformatf("ramp3_duty_b%0d", i + 1), duty[0], ramp_tab[i].duty);
      chk($sformatf("ramp3_busy_b%0d", i + 1), bsy[0], ramp_tab[i].busy);
      chk($sformatf("ramp3_at_b%0d", i + 1), at[0], ramp_tab[i].at_t);
    end

    to_phase(100);
    send(0, 200, 1'b1);
    chk("jump_ready_low", rdy[0], 0);
    to_phase(255);
    chk("jump_ready_p255", rdy[0], 0);
    chk("jump_duty_p255", duty[0], 3);
    cyc();
    chk("jump_duty_p0", duty[0], 200);
    chk("jump_ready_p0", rdy[0], 1);
    chk("jump_at_p0", at[0], 1);

    for (int t = 0; t < 2; t++) begin
      send(1, clamp_tab[t].cmd, 1'b0);
      for (int j = 0; j < 3; j++) begin
        next_boundary();
        chk($sformatf("clamp%0d_step%0d", t, j), duty[1], clamp_tab[t].e[j]);
      end
      chk($sformatf("clamp%0d_at", t), at[1], 1);
    end

    send(0, 0, 1'b1);
    next_boundary();
    chk("zero_jump", duty[0], 0);
    to_phase(20);
    send(0, 50, 1'b0);
    n = 0;
    while (duty[0] != 10 && n < 60) begin
      next_boundary();
      n++;
    end
    chk("boundaries_to_10", n, 40);
    next_boundary();
    next_boundary();
    to_phase(50);
    send(0, 4, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      next_boundary();
      chk($sformatf("retarget_b%0d", i), duty[0], (i < 4) ? 10 : 9);
    end
    repeat (20) next_boundary();
    chk("retarget_final", duty[0], 4);
    chk("retarget_at", at[0], 1);

    send(0, 20, 1'b1);
    next_boundary();
    send(0, 40, 1'b0);
    next_boundary();
    to_phase(30);
    en[0] = 1'b0;
    next_boundary();
    chk("off_duty", duty[0], 0);
    chk("off_busy", bsy[0], 0);
    chk("off_at", at[0], 0);
    chk("off_ready", rdy[0], 1);
    to_phase(60);
    send(0, 6, 1'b0);
    repeat (5) cyc();
    chk("off_still_zero", duty[0], 0);
    en[0] = 1'b1;
    cyc();
    cyc();
    chk("resume_busy", bsy[0], 1);
    repeat (4) next_boundary();
    chk("resume_step", duty[0], 1);
    repeat (40) cyc();

    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_duty", duty[0], 0);
    chk("async_rst_at", at[0], 1);
    chk("async_rst_busy", bsy[0], 0);
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2100) cyc();
    chk("no_resume", duty[0], 0);

    for (int c = 0; c < 15000; c++) begin
      for (int k = 0; k < 2; k++) begin
        v[k]   = ($urandom_range(0, 149) == 0);
        d[k]   = 8'($urandom_range(0, 255));
        imm[k] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 899) == 0) en[k] = ~en[k];
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
